// File: rtl/time_base_pkg.sv
// Shared types and default constants for the time base block.
// Periodic trigger FSM states, snapshot handshake FSM states, default sizing.
// No logic; imported by time_base_gen and tb_mod_cnt users.
package time_base_pkg;

    localparam int unsigned US_PER_MS_DEF = 1000;
    localparam int unsigned MS_PER_S_DEF  = 1000;
    localparam int unsigned TS_W_DEF      = 32;
    localparam int unsigned PER_W_DEF     = 16;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_RUN  = 1'b1
    } per_state_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } snap_state_e;

endpackage

// File: rtl/tb_mod_cnt.sv
// Modulo-MOD event counter: counts tick_in, flags the tick that completes a full period.
// Latency: tick_out is combinational in the same cycle as the completing tick_in.
// Backpressure: none; clr has priority over tick_in and suppresses tick_out.
// Ports: clk, rst_n (async active low), tick_in, clr (sync zero), tick_out (wrap flag).
module tb_mod_cnt #(
    parameter int unsigned MOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    input  logic clr,
    output logic tick_out
);

    localparam int unsigned   CW   = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_out = tick_in & ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_in) begin
            cnt_d = tick_out ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_base_gen.sv
// Time base: derives ms/s strobes, us timestamp, periodic trigger and a timestamp snapshot port.
// Latency: every output is registered; strobes appear one cycle after the qualifying us tick.
// Backpressure: none on the strobe path; snapshot uses a 4-phase req/ack level handshake.
// Ports:
//   clk_sys, rst_n            clock, async active-low reset
//   pluse_us, tb_en, tb_clr   1 us strobe, advance enable, sync clear of the time counters
//   per_cfg/start/stop        periodic interval (us), start (latch cfg), stop
//   snap_req                  snapshot request level
//   pluse_ms, pluse_s         1-cycle ms / s strobes
//   ts_us, sec_cnt            free-running us timestamp and seconds count
//   per_trig, per_busy        periodic strobe, periodic FSM running
//   snap_ack, snap_us/sec     snapshot ack and captured timestamp
module time_base_gen
    import time_base_pkg::*;
#(
    parameter int unsigned US_PER_MS = US_PER_MS_DEF,
    parameter int unsigned MS_PER_S  = MS_PER_S_DEF,
    parameter int unsigned TS_W      = TS_W_DEF,
    parameter int unsigned PER_W     = PER_W_DEF
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             pluse_us,
    input  logic             tb_en,
    input  logic             tb_clr,
    input  logic [PER_W-1:0] per_cfg,
    input  logic             per_start,
    input  logic             per_stop,
    input  logic             snap_req,
    output logic             pluse_ms,
    output logic             pluse_s,
    output logic [TS_W-1:0]  ts_us,
    output logic [31:0]      sec_cnt,
    output logic             per_trig,
    output logic             per_busy,
    output logic             snap_ack,
    output logic [TS_W-1:0]  snap_us,
    output logic [31:0]      snap_sec
);

    logic tick;
    logic ms_wrap;
    logic s_wrap;

    assign tick = pluse_us & tb_en;

    // ------------------------------------------------------------------
    // Prescalers: us -> ms -> s. The ms stage is fed by the combinational
    // wrap of the us stage so the s strobe lines up with the ms strobe.
    // ------------------------------------------------------------------
    tb_mod_cnt #(.MOD(US_PER_MS)) u_us_div (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .tick_in  (tick),
        .clr      (tb_clr),
        .tick_out (ms_wrap)
    );

    tb_mod_cnt #(.MOD(MS_PER_S)) u_ms_div (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .tick_in  (ms_wrap),
        .clr      (tb_clr),
        .tick_out (s_wrap)
    );

    // ------------------------------------------------------------------
    // Timestamp / seconds counters and strobes
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts_q, ts_d;
    logic [31:0]     sec_q, sec_d;
    logic            pms_q, ps_q;

    always_comb begin
        ts_d  = ts_q;
        sec_d = sec_q;
        if (tb_clr) begin
            ts_d  = '0;
            sec_d = '0;
        end else begin
            if (tick) begin
                ts_d = ts_q + TS_W'(1);
            end
            if (s_wrap) begin
                sec_d = sec_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ts_q  <= '0;
            sec_q <= '0;
            pms_q <= 1'b0;
            ps_q  <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            sec_q <= sec_d;
            pms_q <= ms_wrap;   // already gated by tb_en and tb_clr
            ps_q  <= s_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Periodic trigger FSM
    // ------------------------------------------------------------------
    per_state_e      per_state_q, per_state_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] per_lat_q, per_lat_d;
    logic            per_trig_q, per_trig_d;
    logic            per_busy_q;
    logic            cfg_ok;

    assign cfg_ok = (per_cfg != '0);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            per_state_q <= P_IDLE;
            per_cnt_q   <= '0;
            per_lat_q   <= '0;
            per_trig_q  <= 1'b0;
            per_busy_q  <= 1'b0;
        end else begin
            per_state_q <= per_state_d;
            per_cnt_q   <= per_cnt_d;
            per_lat_q   <= per_lat_d;
            per_trig_q  <= per_trig_d;
            per_busy_q  <= (per_state_d == P_RUN);
        end
    end

    // Stop wins over a coincident start.
    always_comb begin
        per_state_d = per_state_q;
        if (per_stop) begin
            per_state_d = P_IDLE;
        end else if (per_start && cfg_ok) begin
            per_state_d = P_RUN;
        end
    end

    // A (re)start reloads the count without triggering; a clear realigns
    // the running interval to the freshly zeroed timestamp.
    always_comb begin
        per_cnt_d  = per_cnt_q;
        per_lat_d  = per_lat_q;
        per_trig_d = 1'b0;
        if (!per_stop) begin
            if (per_start && cfg_ok) begin
                per_lat_d = per_cfg;
                per_cnt_d = per_cfg;
            end else if (per_state_q == P_RUN) begin
                if (tb_clr) begin
                    per_cnt_d = per_lat_q;
                end else if (tick) begin
                    if (per_cnt_q == PER_W'(1)) begin
                        per_trig_d = 1'b1;
                        per_cnt_d  = per_lat_q;
                    end else begin
                        per_cnt_d = per_cnt_q - PER_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot handshake FSM
    // ------------------------------------------------------------------
    snap_state_e     snap_state_q, snap_state_d;
    logic [TS_W-1:0] snap_us_q, snap_us_d;
    logic [31:0]     snap_sec_q, snap_sec_d;
    logic            snap_ack_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            snap_state_q <= S_IDLE;
            snap_us_q    <= '0;
            snap_sec_q   <= '0;
            snap_ack_q   <= 1'b0;
        end else begin
            snap_state_q <= snap_state_d;
            snap_us_q    <= snap_us_d;
            snap_sec_q   <= snap_sec_d;
            snap_ack_q   <= (snap_state_d == S_HOLD);
        end
    end

    always_comb begin
        snap_state_d = snap_state_q;
        case (snap_state_q)
            S_IDLE:  if (snap_req)  snap_state_d = S_HOLD;
            S_HOLD:  if (!snap_req) snap_state_d = S_IDLE;
            default: snap_state_d = S_IDLE;
        endcase
    end

    // Capture the registered values, i.e. the timestamp before this cycle's update.
    always_comb begin
        snap_us_d  = snap_us_q;
        snap_sec_d = snap_sec_q;
        if ((snap_state_q == S_IDLE) && snap_req) begin
            snap_us_d  = ts_q;
            snap_sec_d = sec_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pluse_ms = pms_q;
    assign pluse_s  = ps_q;
    assign ts_us    = ts_q;
    assign sec_cnt  = sec_q;
    assign per_trig = per_trig_q;
    assign per_busy = per_busy_q;
    assign snap_ack = snap_ack_q;
    assign snap_us  = snap_us_q;
    assign snap_sec = snap_sec_q;

endmodule

// File: tb/tb_time_base_gen.sv
module tb_time_base_gen;

    localparam int US = 4;
    localparam int MS = 3;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        pluse_us, tb_en, tb_clr;
    logic [15:0] per_cfg;
    logic        per_start, per_stop, snap_req;
    logic        pluse_ms, pluse_s, per_trig, per_busy, snap_ack;
    logic [31:0] ts_us, sec_cnt, snap_us, snap_sec;

    time_base_gen #(.US_PER_MS(US), .MS_PER_S(MS), .TS_W(32), .PER_W(16)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .tb_en(tb_en),
        .tb_clr(tb_clr), .per_cfg(per_cfg), .per_start(per_start), .per_stop(per_stop),
        .snap_req(snap_req), .pluse_ms(pluse_ms), .pluse_s(pluse_s), .ts_us(ts_us),
        .sec_cnt(sec_cnt), .per_trig(per_trig), .per_busy(per_busy), .snap_ack(snap_ack),
        .snap_us(snap_us), .snap_sec(snap_sec)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int pdiv   = 0;

    // Reference model state: ticks counted since the last clear, plus the
    // observable quantities derived from it.
    longint      m_T;
    logic [31:0] m_ts, m_sec;
    logic        e_pms, e_ps, e_trig;
    logic        m_busy;
    int          m_per, m_el;
    logic        m_shold;
    logic [31:0] m_sus, m_ssec;

    int n_pms, n_ps, n_trig;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_T = 0; m_ts = '0; m_sec = '0;
        e_pms = 1'b0; e_ps = 1'b0; e_trig = 1'b0;
        m_busy = 1'b0; m_per = 0; m_el = 0;
        m_shold = 1'b0; m_sus = '0; m_ssec = '0;
    endtask

    task automatic model();
        logic tick;
        tick = pluse_us && tb_en;
        if (!m_shold && snap_req) begin
            m_shold = 1'b1; m_sus = m_ts; m_ssec = m_sec;
        end else if (m_shold && !snap_req) begin
            m_shold = 1'b0;
        end
        e_pms = 1'b0; e_ps = 1'b0; e_trig = 1'b0;
        if (tb_clr) begin
            m_T = 0; m_ts = '0; m_sec = '0;
        end else if (tick) begin
            m_T++;
            m_ts = m_ts + 32'd1;
            if (m_T % US == 0) e_pms = 1'b1;
            if (m_T % (US * MS) == 0) begin
                e_ps = 1'b1;
                m_sec = m_sec + 32'd1;
            end
        end
        if (per_stop) begin
            m_busy = 1'b0;
        end else if (per_start && per_cfg != 16'd0) begin
            m_busy = 1'b1; m_per = int'(per_cfg); m_el = 0;
        end else if (m_busy) begin
            if (tb_clr) begin
                m_el = 0;
            end else if (tick) begin
                m_el++;
                if (m_el == m_per) begin
                    e_trig = 1'b1; m_el = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("pluse_ms", 64'(pluse_ms), 64'(e_pms));
        check("pluse_s",  64'(pluse_s),  64'(e_ps));
        check("ts_us",    64'(ts_us),    64'(m_ts));
        check("sec_cnt",  64'(sec_cnt),  64'(m_sec));
        check("per_trig", 64'(per_trig), 64'(e_trig));
        check("per_busy", 64'(per_busy), 64'(m_busy));
        check("snap_ack", 64'(snap_ack), 64'(m_shold));
        check("snap_us",  64'(snap_us),  64'(m_sus));
        check("snap_sec", 64'(snap_sec), 64'(m_ssec));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pluse_ms"}, 64'(pluse_ms), 64'd0);
        check({tag, "_pluse_s"},  64'(pluse_s),  64'd0);
        check({tag, "_ts_us"},    64'(ts_us),    64'd0);
        check({tag, "_sec_cnt"},  64'(sec_cnt),  64'd0);
        check({tag, "_per_trig"}, 64'(per_trig), 64'd0);
        check({tag, "_per_busy"}, 64'(per_busy), 64'd0);
        check({tag, "_snap_ack"}, 64'(snap_ack), 64'd0);
        check({tag, "_snap_us"},  64'(snap_us),  64'd0);
        check({tag, "_snap_sec"}, 64'(snap_sec), 64'd0);
    endtask

    // One clock: pluse_us every fifth cycle, model advanced with the inputs
    // seen at the edge, then single-cycle controls are dropped.
    task automatic step();
        pluse_us = (pdiv == 4);
        pdiv = (pdiv == 4) ? 0 : pdiv + 1;
        @(posedge clk_sys);
        #1;
        model();
        compare_all();
        n_pms += int'(pluse_ms);
        n_ps += int'(pluse_s);
        n_trig += int'(per_trig);
        pluse_us = 1'b0; tb_clr = 1'b0; per_start = 1'b0; per_stop = 1'b0;
    endtask

    task automatic run_ticks(input string tag, input int n);
        longint t0;
        int     guard;
        t0 = m_T; guard = 0;
        while (m_T < t0 + n && guard < 10 * n + 20) begin
            step();
            guard++;
        end
        check({tag, "_timeout"}, 64'(m_T - t0), 64'(n));
    endtask

    initial begin
        logic [31:0] ts_hold;
        int          guard;

        rst_n = 1'b0; pluse_us = 1'b0; tb_en = 1'b0; tb_clr = 1'b0;
        per_cfg = '0; per_start = 1'b0; per_stop = 1'b0; snap_req = 1'b0;
        m_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // 12 ticks: three ms strobes, one s strobe
        tb_en = 1'b1;
        n_pms = 0; n_ps = 0; n_trig = 0;
        run_ticks("first12", 12);
        check("first12_ts", 64'(ts_us), 64'd12);
        check("first12_sec", 64'(sec_cnt), 64'd1);
        check("first12_nms", 64'(n_pms), 64'd3);
        check("first12_ns", 64'(n_ps), 64'd1);

        // Periodic trigger every 3 ticks
        per_cfg = 16'd3; per_start = 1'b1; step();
        n_trig = 0;
        run_ticks("per3", 9);
        check("per3_ntrig", 64'(n_trig), 64'd3);
        per_stop = 1'b1; per_start = 1'b1; step();
        check("stop_wins_busy", 64'(per_busy), 64'd0);

        // Zero interval ignored; restart mid-count
        per_cfg = 16'd0; per_start = 1'b1; step();
        check("cfg0_busy", 64'(per_busy), 64'd0);
        per_cfg = 16'd3; per_start = 1'b1; step();
        run_ticks("pre_restart", 1);
        per_cfg = 16'd5; per_start = 1'b1; step();
        n_trig = 0;
        run_ticks("restart4", 4);
        check("restart_no_early", 64'(n_trig), 64'd0);
        run_ticks("restart5", 1);
        check("restart_trig", 64'(per_trig), 64'd1);
        per_stop = 1'b1; step();

        // Clear coincident with a tick at ts_us=7
        tb_clr = 1'b1; step();
        guard = 0;
        while (!(m_ts == 32'd7 && pdiv == 4) && guard < 200) begin step(); guard++; end
        check("clr_align_timeout", 64'(guard < 200), 64'd1);
        tb_clr = 1'b1; step();
        check("clr_ts", 64'(ts_us), 64'd0);
        check("clr_no_ms", 64'(pluse_ms), 64'd0);

        // Frozen time base for ten pulse periods
        tb_en = 1'b0; ts_hold = ts_us;
        repeat (50) step();
        check("frozen_ts", 64'(ts_us), 64'(ts_hold));

        // Snapshot at ts_us = 0x1234
        force dut.ts_q = 32'h0000_1230;
        m_ts = 32'h0000_1230;
        step();
        release dut.ts_q;
        step();
        tb_en = 1'b1;
        guard = 0;
        while (m_ts != 32'h0000_1234 && guard < 200) begin step(); guard++; end
        check("snap_align_timeout", 64'(guard < 200), 64'd1);
        snap_req = 1'b1; step();
        check("snap_ack_hi", 64'(snap_ack), 64'd1);
        check("snap_us_val", 64'(snap_us), 64'h1234);
        repeat (30) step();
        check("snap_held", 64'(snap_us), 64'h1234);
        check("snap_ts_moved", 64'(ts_us > 32'h1234), 64'd1);
        snap_req = 1'b0; step();
        check("snap_ack_lo", 64'(snap_ack), 64'd0);

        // Timestamp wrap
        tb_en = 1'b0;
        force dut.ts_q = 32'hFFFF_FFFE;
        m_ts = 32'hFFFF_FFFE;
        step();
        release dut.ts_q;
        step();
        tb_en = 1'b1;
        run_ticks("wrap", 3);
        check("wrap_ts", 64'(ts_us), 64'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tb_en     = ($urandom_range(0, 9) != 0);
            tb_clr    = ($urandom_range(0, 99) == 0);
            per_cfg   = 16'($urandom_range(0, 6));
            per_start = ($urandom_range(0, 29) == 0);
            per_stop  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 19) == 0) snap_req = ~snap_req;
            step();
        end

        // Asynchronous reset while running
        tb_en = 1'b1; tb_clr = 1'b0; snap_req = 1'b1;
        per_cfg = 16'd2; per_start = 1'b1; step();
        n_trig = 0;
        run_ticks("pre_rst", 5);
        check("pre_rst_busy", 64'(per_busy), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_zero("async_rst");
        snap_req = 1'b0;
        repeat (6) begin
            pluse_us = 1'b1;
            @(posedge clk_sys);
            #1;
            check("rst_hold_ms", 64'(pluse_ms), 64'd0);
            check("rst_hold_trig", 64'(per_trig), 64'd0);
        end
        pluse_us = 1'b0;
        check_zero("rst_hold");
        rst_n = 1'b1;
        pdiv = 0;
        run_ticks("post_rst", 4);
        check("post_rst_ts", 64'(ts_us), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
